lsu_bus_master: RTL and testbench

- Load/store initiator between the core's memory stage and the data-side memory bus, i.e. the requesting end of the REQ/GNT data port served by the ROM/RAM responders.
- Accepts one access at a time from the core and drives REQ/CE/HB/ADDR, holding them until GNT.
- Returns zero- or sign-extended load data, or reports misalignment or bus timeout.
- Responders perform the lane select and sign extension; this block only zero-masks for unsigned loads.

---
 rtl/lsu_bus_master.sv | 149 ++++++++++++++
 tb/tb_lsu_bus_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: one access at a time from the core onto the REQ/GNT data port.
// Drives registered request fields until grant, then returns load data or a misalign/timeout error.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_VALID,
    input  logic        i_WE,
    input  logic [1:0]  i_SIZE,
    input  logic        i_UNSIGNED,
    input  logic [31:0] i_ADDR,
    input  logic [31:0] i_WDATA,
    output logic        o_READY,
    output logic        o_DONE,
    output logic [31:0] o_RDATA,
    output logic        o_MISALIGN,
    output logic        o_BUSERR,
    output logic        o_REQ,
    output logic        o_CE,
    output logic        o_WE,
    output logic [1:0]  o_HB,
    output logic [31:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BE,
    input  logic        i_GNT,
    input  logic [31:0] i_RDATA
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      rdata_q;
    logic             mis_q;
    logic [CNT_W-1:0] cnt;

    logic        misalign;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] load_ext;
    logic        timeout_hit;

    // Lane replication and byte enables are computed at acceptance so the bus fields come straight from flops.
    always_comb begin
        lane_wdata = i_WDATA;
        lane_be    = 4'b1111;
        case (i_SIZE)
            2'b00: begin
                lane_wdata = {4{i_WDATA[7:0]}};
                lane_be    = 4'b0001 << i_ADDR[1:0];
            end
            2'b01: begin
                lane_wdata = {2{i_WDATA[15:0]}};
                lane_be    = 4'b0011 << i_ADDR[1:0];
            end
            default: ;
        endcase
        if (!i_WE) lane_be = '0;
    end

    assign misalign = (i_SIZE == 2'b11)
                    | ((i_SIZE == 2'b01) & i_ADDR[0])
                    | ((i_SIZE == 2'b10) & (|i_ADDR[1:0]));

    always_comb begin
        load_ext = i_RDATA;
        if (we_q) begin
            load_ext = '0;
        end else if (uns_q) begin
            if (size_q == 2'b00) load_ext = {24'b0, i_RDATA[7:0]};
            else if (size_q == 2'b01) load_ext = {16'b0, i_RDATA[15:0]};
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (i_GNT) begin
                        rdata_q <= load_ext;
                        cnt     <= '0;
                        state   <= S_RESP;
                    end else if (timeout_hit) begin
                        cnt     <= '0;
                        state   <= S_ERR;
                    end else begin
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE, RESP and ERR all present o_READY, so each can accept the next access.
                    if (i_VALID) begin
                        we_q    <= i_WE;
                        size_q  <= i_SIZE;
                        uns_q   <= i_UNSIGNED;
                        addr_q  <= i_ADDR;
                        wdata_q <= lane_wdata;
                        be_q    <= lane_be;
                        rdata_q <= '0;
                        mis_q   <= misalign;
                        cnt     <= '0;
                        state   <= misalign ? S_ERR : S_REQ;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_READY    = (state != S_REQ);
    assign o_DONE     = (state == S_RESP) | (state == S_ERR);
    assign o_RDATA    = (state == S_RESP) ? rdata_q : '0;
    assign o_MISALIGN = (state == S_ERR) & mis_q;
    assign o_BUSERR   = (state == S_ERR) & ~mis_q;
    assign o_REQ      = (state == S_REQ);
    assign o_CE       = o_REQ;
    assign o_WE       = we_q;
    assign o_HB       = size_q;
    assign o_ADDR     = addr_q;
    assign o_WDATA    = wdata_q;
    assign o_BE       = be_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: stimulus queues expected bus/response records,
// a negedge monitor checks them as the DUT presents REQ pulses and DONE cycles.
module tb_lsu_bus_master;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_VALID;
    logic        i_WE;
    logic [1:0]  i_SIZE;
    logic        i_UNSIGNED;
    logic [31:0] i_ADDR;
    logic [31:0] i_WDATA;
    logic        o_READY;
    logic        o_DONE;
    logic [31:0] o_RDATA;
    logic        o_MISALIGN;
    logic        o_BUSERR;
    logic        o_REQ;
    logic        o_CE;
    logic        o_WE;
    logic [1:0]  o_HB;
    logic [31:0] o_ADDR;
    logic [31:0] o_WDATA;
    logic [3:0]  o_BE;
    logic        i_GNT;
    logic [31:0] i_RDATA;

    lsu_bus_master #(.TIMEOUT(16), .CNT_W(8)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_VALID(i_VALID), .i_WE(i_WE), .i_SIZE(i_SIZE),
        .i_UNSIGNED(i_UNSIGNED), .i_ADDR(i_ADDR), .i_WDATA(i_WDATA), .o_READY(o_READY),
        .o_DONE(o_DONE), .o_RDATA(o_RDATA), .o_MISALIGN(o_MISALIGN), .o_BUSERR(o_BUSERR),
        .o_REQ(o_REQ), .o_CE(o_CE), .o_WE(o_WE), .o_HB(o_HB), .o_ADDR(o_ADDR),
        .o_WDATA(o_WDATA), .o_BE(o_BE), .i_GNT(i_GNT), .i_RDATA(i_RDATA)
    );

    always #5 i_CLK = ~i_CLK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [70:0] exp_bus[$];
    int          exp_len[$];
    logic [33:0] exp_rsp[$];

    int          gnt_delay = -1;
    logic [31:0] rsp_data  = '0;
    bit          stray_gnt = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder: grants after gnt_delay REQ cycles (-1 never), optionally drives a stray grant while idle.
    initial begin
        int rsp_cnt;
        rsp_cnt = 0;
        i_GNT   = 1'b0;
        i_RDATA = '0;
        forever begin
            @(negedge i_CLK);
            if (o_REQ && !i_RST) begin
                if (gnt_delay >= 0 && rsp_cnt == gnt_delay) begin
                    i_GNT   = 1'b1;
                    i_RDATA = rsp_data;
                end else begin
                    i_GNT   = 1'b0;
                    i_RDATA = '0;
                end
                rsp_cnt++;
            end else begin
                rsp_cnt = 0;
                i_GNT   = stray_gnt;
                i_RDATA = stray_gnt ? rsp_data : '0;
            end
        end
    end

    // Monitor: checks bus fields at each REQ rise, pulse length at each fall, and every DONE response.
    initial begin
        bit prev_req;
        int req_len;
        prev_req = 1'b0;
        req_len  = 0;
        forever begin
            @(negedge i_CLK);
            if (i_RST) begin
                prev_req = 1'b0;
                req_len  = 0;
            end else begin
                if (o_REQ && !prev_req) begin
                    if (exp_bus.size() == 0) chk("unexpected_req", 96'(o_REQ), 96'(0));
                    else chk("bus_fields", {o_WE, o_HB, o_ADDR, o_WDATA, o_BE}, exp_bus.pop_front());
                    chk("ce_eq_req", 96'(o_CE), 96'(o_REQ));
                    req_len = 1;
                end else if (o_REQ) begin
                    req_len++;
                end
                if (!o_REQ && prev_req) begin
                    if (exp_len.size() == 0) chk("unexpected_req_end", 96'(req_len), 96'(0));
                    else chk("req_len", 96'(req_len), 96'(exp_len.pop_front()));
                end
                if (o_DONE) begin
                    if (exp_rsp.size() == 0) chk("unexpected_done", 96'(o_DONE), 96'(0));
                    else chk("response", {o_RDATA, o_MISALIGN, o_BUSERR}, exp_rsp.pop_front());
                end
                if (o_DONE || o_MISALIGN || o_BUSERR)
                    chk("err_flags_legal", 96'((o_MISALIGN & o_BUSERR) | ((o_MISALIGN | o_BUSERR) & ~o_DONE)), 96'(0));
                prev_req = o_REQ;
            end
        end
    end

    // Called at a negedge; presents the access for one cycle and returns at the following negedge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rsp,
                         input int dly, input logic [31:0] exp_rd, input logic mis, input logic berr,
                         input int len, input logic [31:0] exp_wd, input logic [3:0] exp_be,
                         input bit abort);
        gnt_delay = dly;
        rsp_data  = rsp;
        if (!mis) exp_bus.push_back({we, size, addr, exp_wd, exp_be});
        if (!mis && !abort) exp_len.push_back(len);
        if (!abort) exp_rsp.push_back({exp_rd, mis, berr});
        i_VALID    = 1'b1;
        i_WE       = we;
        i_SIZE     = size;
        i_UNSIGNED = uns;
        i_ADDR     = addr;
        i_WDATA    = wdata;
        @(negedge i_CLK);
        i_VALID    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int t;
        t = 1;
        while (!o_DONE && t < 100) begin
            @(negedge i_CLK);
            t++;
        end
        chk(name, 96'(t), 96'(exp_lat));
    endtask

    initial begin
        i_RST = 1'b1; i_VALID = 1'b0; i_WE = 1'b0; i_SIZE = '0;
        i_UNSIGNED = 1'b0; i_ADDR = '0; i_WDATA = '0;
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b0;
        @(negedge i_CLK);
        chk("reset_outputs", {o_READY, o_DONE, o_REQ, o_CE, o_MISALIGN, o_BUSERR, o_WE, o_HB, o_BE},
            {1'b1, 12'b0});
        chk("reset_data", {o_RDATA, o_ADDR, o_WDATA}, 96'(0));

        // Word load, immediate grant: REQ exactly one cycle
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 4'b0000, 0);
        wait_done("lat_lw", 2);
        // LBU / LB / LHU at odd and half addresses
        issue(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, 32'h00000080, 0, 0, 1, 32'h0, 4'b0000, 0);
        wait_done("lat_lbu", 2);
        issue(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 32'hFFFFFF80, 0, 0, 1, 32'h0, 4'b0000, 0);
        wait_done("lat_lb", 2);
        issue(0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 32'h00008001, 0, 0, 1, 32'h0, 4'b0000, 0);
        wait_done("lat_lhu", 2);
        // Stores: lane replication, byte enables, zero read result despite responder data
        issue(1, 2'b01, 0, 32'h22, 32'hA5A51234, 32'hCAFEF00D, 0, 32'h0, 0, 0, 1, 32'h12341234, 4'b1100, 0);
        wait_done("lat_sh", 2);
        issue(1, 2'b00, 0, 32'h11, 32'hFFFFFF5A, 32'hCAFEF00D, 0, 32'h0, 0, 0, 1, 32'h5A5A5A5A, 4'b0010, 0);
        wait_done("lat_sb", 2);
        issue(1, 2'b10, 0, 32'h24, 32'h01234567, 32'hCAFEF00D, 0, 32'h0, 0, 0, 1, 32'h01234567, 4'b1111, 0);
        wait_done("lat_sw", 2);
        // Misaligned and reserved-size accesses: DONE next cycle, no REQ
        issue(0, 2'b10, 0, 32'h21, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 0);
        wait_done("lat_mis_lw", 1);
        issue(0, 2'b01, 0, 32'h23, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 0);
        wait_done("lat_mis_lh", 1);
        issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 0);
        wait_done("lat_rsvd", 1);
        // Grant withheld: 16 REQ cycles then BUSERR
        issue(0, 2'b10, 0, 32'h40, 32'h0, 32'h77777777, -1, 32'h0, 0, 1, 16, 32'h0, 4'b0000, 0);
        wait_done("lat_timeout", 17);
        // Stray grant while idle must be ignored
        stray_gnt = 1'b1;
        rsp_data  = 32'h12345678;
        repeat (4) @(negedge i_CLK);
        chk("stray_idle", {o_READY, o_DONE, o_REQ}, {1'b1, 1'b0, 1'b0});
        stray_gnt = 1'b0;
        @(negedge i_CLK);
        // Grant on the cycle the timeout would fire: grant wins
        issue(0, 2'b10, 0, 32'h44, 32'h0, 32'h0BADF00D, 15, 32'h0BADF00D, 0, 0, 16, 32'h0, 4'b0000, 0);
        wait_done("lat_gnt_at_limit", 17);
        // Back-to-back: second access accepted in the first one's DONE cycle
        issue(0, 2'b10, 0, 32'h50, 32'h0, 32'h11111111, 1, 32'h11111111, 0, 0, 2, 32'h0, 4'b0000, 0);
        wait_done("lat_b2b_a", 3);
        issue(0, 2'b01, 0, 32'h52, 32'h0, 32'hFFFF8002, 1, 32'hFFFF8002, 0, 0, 2, 32'h0, 4'b0000, 0);
        wait_done("lat_b2b_b", 3);
        // Asynchronous reset while REQ is held
        issue(0, 2'b10, 0, 32'h60, 32'h0, 32'h0, -1, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 1);
        repeat (2) @(negedge i_CLK);
        chk("req_before_rst", 96'(o_REQ), 96'(1));
        #2 i_RST = 1'b1;
        #1 chk("async_rst", {o_REQ, o_CE, o_READY, o_DONE}, {1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge i_CLK);
        i_RST = 1'b0;
        @(negedge i_CLK);
        chk("after_rst", {o_REQ, o_READY, o_DONE}, {1'b0, 1'b1, 1'b0});
        issue(0, 2'b00, 1, 32'h61, 32'h0, 32'hFFFFFFC3, 0, 32'h000000C3, 0, 0, 1, 32'h0, 4'b0000, 0);
        wait_done("lat_post_rst", 2);

        repeat (3) @(negedge i_CLK);
        chk("rsp_queue_empty", 96'(exp_rsp.size()), 96'(0));
        chk("bus_queue_empty", 96'(exp_bus.size() + exp_len.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
